// File: rtl/sumador_restador_serie_if.sv
// Handshake and data bundle for the digit-serial adder/subtractor.
// master: the producer/consumer side. slave: the arithmetic block.
interface sumador_restador_serie_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, res, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, res, carry, overflow, zero
  );
endinterface

// File: rtl/sumador_restador_serie.sv
// Digit-serial two's-complement adder/subtractor.
// Adds DIGIT bits per clock over NDIG = WIDTH/DIGIT cycles, then holds the
// result with carry/borrow, signed-overflow and zero flags until consumed.
// Optional feature macro: SUMRES_SAT_EN (saturate res to the signed limit on
// overflow). Without it res wraps modulo 2^WIDTH.
module sumador_restador_serie #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  sumador_restador_serie_if.slave   bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("sumador_restador_serie: WIDTH must be a multiple of DIGIT");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("sumador_restador_serie: WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             op_q;
  logic             c_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q, ovf_q, zero_q;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_nx, res_fin;
  logic             ovf_nx;
  logic             last;

  assign last          = (k_q == KW'(NDIG - 1));
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = res_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

  // One digit of the ripple sum; on the last digit also the full result,
  // its signed-overflow flag and the (optionally saturated) final value.
  always_comb begin
    dsum   = {1'b0, opa_q[k_q*DIGIT +: DIGIT]} + {1'b0, opb_q[k_q*DIGIT +: DIGIT]}
           + {{DIGIT{1'b0}}, c_q};
    res_nx = res_q;
    res_nx[k_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    ovf_nx  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (res_nx[WIDTH-1] != opa_q[WIDTH-1]);
    res_fin = res_nx;
`ifdef SUMRES_SAT_EN
    if (ovf_nx)
      res_fin = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept in IDLE, leave CALC after the last digit, drain DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept (B inverted, cin=1 for subtract),
  // write one result slice per CALC cycle, register flags with the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= 1'b0;
      c_q     <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opa_q <= bus.a;
            opb_q <= bus.op ? ~bus.b : bus.b;
            op_q  <= bus.op;
            c_q   <= bus.op;
            k_q   <= '0;
          end
        end
        CALC: begin
          c_q <= dsum[DIGIT];
          k_q <= k_q + KW'(1);
          if (last) begin
            res_q   <= res_fin;
            carry_q <= op_q ^ dsum[DIGIT];
            ovf_q   <= ovf_nx;
            zero_q  <= (res_fin == '0);
          end else begin
            res_q <= res_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sumador_restador_serie.sv
// Bench for sumador_restador_serie: directed and random ops on an 8-bit,
// 2-bit-digit instance plus an exhaustive subtract sweep on a 3-bit,
// 1-bit-digit instance, checked against an arithmetic reference model.
module tb_sumador_restador_serie;
  logic clk = 1'b0;
  logic rst8, rst3;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sumador_restador_serie_if #(.WIDTH(8)) if8 ();
  sumador_restador_serie_if #(.WIDTH(3)) if3 ();

  sumador_restador_serie #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));
  sumador_restador_serie #(.WIDTH(3), .DIGIT(1)) dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       ovf;
    logic       zero;
  } exp_t;

  exp_t ex;

  // Reference: true signed/unsigned results from plain integer arithmetic.
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic op);
    exp_t e;
    int sa, sb, sr, ur;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op) begin
      sr = sa - sb;
      ur = int'(a) - int'(b);
      e.carry = (a < b);
    end else begin
      sr = sa + sb;
      ur = int'(a) + int'(b);
      e.carry = (ur > 255);
    end
    e.res = ur[7:0];
    e.ovf = (sr > 127) || (sr < -128);
`ifdef SUMRES_SAT_EN
    if (e.ovf) e.res = (sa < 0) ? 8'h80 : 8'h7F;
`endif
    e.zero = (e.res == 8'h00);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_flags8(input string tag);
    chk({tag, "_res"},   32'(if8.res),      32'(ex.res));
    chk({tag, "_carry"}, 32'(if8.carry),    32'(ex.carry));
    chk({tag, "_ovf"},   32'(if8.overflow), 32'(ex.ovf));
    chk({tag, "_zero"},  32'(if8.zero),     32'(ex.zero));
  endtask

  // Present one op and let it be accepted on the next rising edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic op);
    chk("in_ready_idle", 32'(if8.in_ready), 32'd1);
    if8.a = a; if8.b = b; if8.op = op; if8.in_valid = 1'b1;
    ex = model8(a, b, op);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.op = 1'($urandom);
  endtask

  // Check exact latency, result, backpressure hold and the drain handshake.
  // With inject set, a new op is offered throughout the hold and left pending.
  task automatic complete8(input int hold, input bit inject,
                           input logic [7:0] na, input logic [7:0] nb, input logic nop);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        chk("calc_out_valid", 32'(if8.out_valid), 32'd0);
        chk("calc_in_ready",  32'(if8.in_ready),  32'd0);
      end
    end
    chk("done_out_valid", 32'(if8.out_valid), 32'd1);
    chk_flags8("done");
    if (inject) begin
      if8.a = na; if8.b = nb; if8.op = nop; if8.in_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(if8.out_valid), 32'd1);
      chk("hold_in_ready",  32'(if8.in_ready),  32'd0);
      chk_flags8("hold");
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    chk("drain_out_valid", 32'(if8.out_valid), 32'd0);
    chk("drain_in_ready",  32'(if8.in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    rst8 = 1'b1; rst3 = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.op = 1'b0; if8.out_ready = 1'b0;
    if3.in_valid = 1'b0; if3.a = '0; if3.b = '0; if3.op = 1'b0; if3.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_in_ready",  32'(if8.in_ready),  32'd1);
    chk("rst_res",       32'(if8.res),       32'd0);
    chk("rst_flags",     32'({if8.carry, if8.overflow, if8.zero}), 32'd0);
    chk("rst3_in_ready", 32'(if3.in_ready),  32'd1);
    rst8 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    issue8(8'd100, 8'd27, 1'b0);  complete8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    issue8(8'd3, 8'd5, 1'b1);     complete8(1, 1'b0, 8'h00, 8'h00, 1'b0);
    issue8(8'h55, 8'h55, 1'b1);   complete8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    issue8(8'd100, 8'd100, 1'b0); complete8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    issue8(8'h80, 8'h01, 1'b1);   complete8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    issue8(8'hFF, 8'h01, 1'b0);   complete8(0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Backpressure with a new op offered; it is taken only after the drain.
    issue8(8'h11, 8'h22, 1'b0);   complete8(5, 1'b1, 8'h10, 8'h20, 1'b1);
    issue8(8'h10, 8'h20, 1'b1);   complete8(0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset during the second CALC cycle aborts the op.
    issue8(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("abort_out_valid", 32'(if8.out_valid), 32'd0);
    chk("abort_in_ready",  32'(if8.in_ready),  32'd1);
    chk("abort_res",       32'(if8.res),       32'd0);
    chk("abort_flags",     32'({if8.carry, if8.overflow, if8.zero}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_stale", 32'(if8.out_valid), 32'd0);
    end
    issue8(8'h7F, 8'h80, 1'b1);   complete8(0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random ops with random backpressure.
    for (int n = 0; n < 30; n++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      complete8(int'($urandom_range(0, 3)), 1'b0, 8'h00, 8'h00, 1'b0);
    end

    // WIDTH=3, DIGIT=1: every subtract pair; out_valid 3 cycles after accept.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        chk("w3_in_ready", 32'(if3.in_ready), 32'd1);
        if3.a = 3'(a); if3.b = 3'(b); if3.op = 1'b1; if3.in_valid = 1'b1;
        @(posedge clk); #1;
        if3.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("w3_early_valid", 32'(if3.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("w3_out_valid", 32'(if3.out_valid), 32'd1);
        chk("w3_res",       32'(if3.res),       32'((a - b) & 7));
        chk("w3_borrow",    32'(if3.carry),     32'(a < b));
        if3.out_ready = 1'b1;
        @(posedge clk); #1;
        if3.out_ready = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
